// File: rtl/flit_assembler_pkg.sv
// Shared flit field widths, packet/width encodings and the flits-per-packet rule.
// Used by the reassembly slots and by the top-level lookup/output logic.
package flit_assembler_pkg;

    localparam int TYPE_W  = 3;
    localparam int WIDTH_W = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [TYPE_W-1:0] {
        DMEM_REQ_READ     = 3'd0,
        DMEM_REQ_WRITE    = 3'd1,
        DMEM_RESP_DATA    = 3'd2,
        DMEM_RESP_WRITTEN = 3'd3,
        DMEM_RESP_BAD     = 3'd4,
        IMEM_REQ_READ     = 3'd5,
        IMEM_RESP_DATA    = 3'd6,
        IMEM_RESP_BAD     = 3'd7
    } type_packet_type;

    typedef enum logic [WIDTH_W-1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    // Address/header flits plus data flits; the reserved width code counts as a word.
    function automatic logic [CNT_W-1:0] flit_count(input logic [TYPE_W-1:0]  ptype,
                                                    input logic [WIDTH_W-1:0] width);
        logic [CNT_W-1:0] data_flits;
        logic [CNT_W-1:0] total;
        case (type_scr1_mem_width_e'(width))
            SCR1_MEM_WIDTH_BYTE:  data_flits = 4'd1;
            SCR1_MEM_WIDTH_HWORD: data_flits = 4'd2;
            default:              data_flits = 4'd4;
        endcase
        case (type_packet_type'(ptype))
            DMEM_RESP_WRITTEN,
            DMEM_RESP_BAD,
            IMEM_RESP_BAD:  total = 4'd1;
            DMEM_REQ_READ,
            IMEM_REQ_READ:  total = 4'd4;
            default:        total = 4'd4 + data_flits;
        endcase
        return total;
    endfunction

endpackage

// File: rtl/flit_assembler_if.sv
// Flit input channel and reassembled-packet output channel of the flit assembler.
// master drives flits and takes packets; slave is the assembler itself.
interface flit_assembler_if
    import flit_assembler_pkg::*;
#(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int MAX_PAYLOAD     = 64,
    parameter int FLIT_PAYLOAD    = 8
);
    localparam int NODE_W     = $clog2(NODE_COUNT);
    localparam int IDX_W      = $clog2(MAX_PAYLOAD / FLIT_PAYLOAD);
    localparam int FLIT_WIDTH = 1 + 2*NODE_W + TYPE_W + WIDTH_W + FLIT_PAYLOAD + PACKET_ID_WIDTH + IDX_W;

    logic [FLIT_WIDTH-1:0]      flit_in;
    logic                       flit_valid;
    logic                       flit_ready;
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [MAX_PAYLOAD-1:0]     pkt_payload;
    logic [TYPE_W-1:0]          pkt_type;
    logic [WIDTH_W-1:0]         pkt_width;
    logic [PACKET_ID_WIDTH-1:0] pkt_id;
    logic [NODE_W-1:0]          pkt_src;
    logic                       drop_err;
    logic                       dup_err;

    modport master (
        output flit_in, flit_valid, pkt_ready,
        input  flit_ready, pkt_valid, pkt_payload, pkt_type, pkt_width, pkt_id, pkt_src,
               drop_err, dup_err
    );

    modport slave (
        input  flit_in, flit_valid, pkt_ready,
        output flit_ready, pkt_valid, pkt_payload, pkt_type, pkt_width, pkt_id, pkt_src,
               drop_err, dup_err
    );

endinterface

// File: rtl/flit_assembler_slot.sv
// One reassembly context: tag, received-index bitmap, distinct-flit count and payload.
// done rises on the edge that accepts the last distinct flit; free_en returns it to idle.
module flit_assembler_slot
    import flit_assembler_pkg::*;
#(
    parameter int NODE_W          = 3,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int MAX_PAYLOAD     = 64,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int IDX_W           = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc,
    input  logic                       wr_en,
    input  logic                       free_en,
    input  logic [IDX_W-1:0]           idx,
    input  logic [FLIT_PAYLOAD-1:0]    data,
    input  logic [TYPE_W-1:0]          ptype,
    input  logic [WIDTH_W-1:0]         width,
    input  logic [PACKET_ID_WIDTH-1:0] id,
    input  logic [NODE_W-1:0]          src,
    output logic                       busy,
    output logic                       done,
    output logic                       seen,
    output logic [TYPE_W-1:0]          slot_type,
    output logic [WIDTH_W-1:0]         slot_width,
    output logic [PACKET_ID_WIDTH-1:0] slot_id,
    output logic [NODE_W-1:0]          slot_src,
    output logic [MAX_PAYLOAD-1:0]     payload
);
    localparam int NBYTES = MAX_PAYLOAD / FLIT_PAYLOAD;

    logic [NBYTES-1:0] bitmap;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  expected;

    assign seen     = bitmap[idx];
    assign cnt_inc  = cnt + 4'd1;
    // The tag is not latched yet on the allocating flit, so size from the flit itself.
    assign expected = alloc ? flit_count(ptype, width) : flit_count(slot_type, slot_width);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            bitmap     <= '0;
            cnt        <= '0;
            payload    <= '0;
            slot_type  <= '0;
            slot_width <= '0;
            slot_id    <= '0;
            slot_src   <= '0;
        end else if (free_en) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bitmap  <= '0;
            cnt     <= '0;
            payload <= '0;
        end else if (alloc || wr_en) begin
            if (alloc) begin
                busy       <= 1'b1;
                slot_type  <= ptype;
                slot_width <= width;
                slot_id    <= id;
                slot_src   <= src;
            end
            payload[idx*FLIT_PAYLOAD +: FLIT_PAYLOAD] <= data;
            // A repeated index only overwrites its byte; it never advances completion.
            if (!seen) begin
                bitmap[idx] <= 1'b1;
                cnt         <= cnt_inc;
                done        <= (cnt_inc == expected);
            end
        end
    end

endmodule

// File: rtl/flit_assembler.sv
// Reassembles NoC flits into packets across SLOTS interleaved contexts; last flit at edge N -> pkt_valid after N+1.
// flit_ready drops only when a new tag finds no free slot; pkt_* hold while pkt_valid & !pkt_ready.
module flit_assembler
    import flit_assembler_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int MAX_PAYLOAD     = 64,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int SLOTS           = 4
) (
    input  logic            clk,
    input  logic            rst,
    flit_assembler_if.slave bus
);
    localparam int NODE_W    = $clog2(NODE_COUNT);
    localparam int IDX_W     = $clog2(MAX_PAYLOAD / FLIT_PAYLOAD);
    localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int OFF_SRC   = IDX_W;
    localparam int OFF_ID    = OFF_SRC + NODE_W;
    localparam int OFF_BYTE  = OFF_ID + PACKET_ID_WIDTH;
    localparam int OFF_WIDTH = OFF_BYTE + FLIT_PAYLOAD;
    localparam int OFF_TYPE  = OFF_WIDTH + WIDTH_W;
    localparam int OFF_DEST  = OFF_TYPE + TYPE_W;
    localparam int OFF_MARK  = OFF_DEST + NODE_W;

    logic [IDX_W-1:0]           f_idx;
    logic [NODE_W-1:0]          f_src;
    logic [PACKET_ID_WIDTH-1:0] f_id;
    logic [FLIT_PAYLOAD-1:0]    f_byte;
    logic [WIDTH_W-1:0]         f_width;
    logic [TYPE_W-1:0]          f_type;
    logic [NODE_W-1:0]          f_dest;
    logic                       f_mark;

    assign f_idx   = bus.flit_in[0         +: IDX_W];
    assign f_src   = bus.flit_in[OFF_SRC   +: NODE_W];
    assign f_id    = bus.flit_in[OFF_ID    +: PACKET_ID_WIDTH];
    assign f_byte  = bus.flit_in[OFF_BYTE  +: FLIT_PAYLOAD];
    assign f_width = bus.flit_in[OFF_WIDTH +: WIDTH_W];
    assign f_type  = bus.flit_in[OFF_TYPE  +: TYPE_W];
    assign f_dest  = bus.flit_in[OFF_DEST  +: NODE_W];
    assign f_mark  = bus.flit_in[OFF_MARK];

    logic [SLOTS-1:0]           busy_vec, done_vec, seen_vec, match_vec;
    logic [SLOTS-1:0]           alloc_vec, wr_vec, free_vec;
    logic [TYPE_W-1:0]          slot_type    [SLOTS];
    logic [WIDTH_W-1:0]         slot_width   [SLOTS];
    logic [PACKET_ID_WIDTH-1:0] slot_id      [SLOTS];
    logic [NODE_W-1:0]          slot_src     [SLOTS];
    logic [MAX_PAYLOAD-1:0]     slot_payload [SLOTS];

    logic              match_any, alloc_any, done_any;
    logic [SLOT_W-1:0] match_sel, alloc_sel, done_sel;
    logic              drop, accept, out_load;

    logic                       pkt_valid_q;
    logic [MAX_PAYLOAD-1:0]     pkt_payload_q;
    logic [TYPE_W-1:0]          pkt_type_q;
    logic [WIDTH_W-1:0]         pkt_width_q;
    logic [PACKET_ID_WIDTH-1:0] pkt_id_q;
    logic [NODE_W-1:0]          pkt_src_q;
    logic                       drop_err_q, dup_err_q;

    always_comb begin
        match_vec = '0;
        for (int s = 0; s < SLOTS; s++) begin
            match_vec[s] = busy_vec[s] & ~done_vec[s] &
                           (slot_src[s] == f_src) & (slot_id[s] == f_id);
        end
    end

    // Lowest-index priority encoders; walking downwards leaves the smallest hit last.
    always_comb begin
        match_any = 1'b0;
        match_sel = '0;
        alloc_any = 1'b0;
        alloc_sel = '0;
        done_any  = 1'b0;
        done_sel  = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (match_vec[s]) begin
                match_any = 1'b1;
                match_sel = SLOT_W'(s);
            end
            if (!busy_vec[s]) begin
                alloc_any = 1'b1;
                alloc_sel = SLOT_W'(s);
            end
            if (done_vec[s]) begin
                done_any = 1'b1;
                done_sel = SLOT_W'(s);
            end
        end
    end

    assign drop           = ~f_mark | (f_dest != NODE_W'(NODE_ID));
    assign bus.flit_ready = drop | match_any | alloc_any;
    assign accept         = bus.flit_valid & ~drop & (match_any | alloc_any);
    assign out_load       = done_any & (~pkt_valid_q | bus.pkt_ready);

    // busy_vec is sampled pre-edge, so a slot freed by out_load is not reallocated this cycle.
    always_comb begin
        wr_vec    = '0;
        alloc_vec = '0;
        free_vec  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            wr_vec[s]    = accept & match_any  & (match_sel == SLOT_W'(s));
            alloc_vec[s] = accept & ~match_any & (alloc_sel == SLOT_W'(s));
            free_vec[s]  = out_load & (done_sel == SLOT_W'(s));
        end
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        flit_assembler_slot #(
            .NODE_W          (NODE_W),
            .PACKET_ID_WIDTH (PACKET_ID_WIDTH),
            .MAX_PAYLOAD     (MAX_PAYLOAD),
            .FLIT_PAYLOAD    (FLIT_PAYLOAD),
            .IDX_W           (IDX_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .alloc      (alloc_vec[s]),
            .wr_en      (wr_vec[s]),
            .free_en    (free_vec[s]),
            .idx        (f_idx),
            .data       (f_byte),
            .ptype      (f_type),
            .width      (f_width),
            .id         (f_id),
            .src        (f_src),
            .busy       (busy_vec[s]),
            .done       (done_vec[s]),
            .seen       (seen_vec[s]),
            .slot_type  (slot_type[s]),
            .slot_width (slot_width[s]),
            .slot_id    (slot_id[s]),
            .slot_src   (slot_src[s]),
            .payload    (slot_payload[s])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_valid_q   <= 1'b0;
            pkt_payload_q <= '0;
            pkt_type_q    <= '0;
            pkt_width_q   <= '0;
            pkt_id_q      <= '0;
            pkt_src_q     <= '0;
            drop_err_q    <= 1'b0;
            dup_err_q     <= 1'b0;
        end else begin
            if (out_load) begin
                pkt_valid_q   <= 1'b1;
                pkt_payload_q <= slot_payload[done_sel];
                pkt_type_q    <= slot_type[done_sel];
                pkt_width_q   <= slot_width[done_sel];
                pkt_id_q      <= slot_id[done_sel];
                pkt_src_q     <= slot_src[done_sel];
            end else if (bus.pkt_ready) begin
                pkt_valid_q <= 1'b0;
            end
            drop_err_q <= bus.flit_valid & drop;
            dup_err_q  <= accept & match_any & seen_vec[match_sel];
        end
    end

    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.pkt_payload = pkt_payload_q;
    assign bus.pkt_type    = pkt_type_q;
    assign bus.pkt_width   = pkt_width_q;
    assign bus.pkt_id      = pkt_id_q;
    assign bus.pkt_src     = pkt_src_q;
    assign bus.drop_err    = drop_err_q;
    assign bus.dup_err     = dup_err_q;

endmodule
